fir_io_driver: RTL and testbench
================================

// Module: fir_io_driver
// PURPOSE
//  Host-side driver for the 6-tap FIR tile. It runs on the system clock and synthesises the tile's 8-bit io_in: bit0 is the FIR clock, bit1 the FIR reset, bits[BW_in+1:2] the data.
//  On start it resets the tile, serially loads N_TAPS coefficients, then streams samples one FIR clock edge per sample.
//  It captures io_out and returns filter results on a valid/ready stream.
// PARAMETERS
//  N_TAPS       6   coefficient count (FIR load length)
//  BW_in        6   coefficient/sample width, two's complement
//  BW_out       8   result width read from fir_io_out
//  HALF_PERIOD  4   sys clocks per FIR clock phase (>=3)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high
//  cfg_we       in   1       coefficient write strobe
//  cfg_addr     in   3       coefficient index (multiplies sample delayed by cfg_addr)
//  cfg_data     in   BW_in   coefficient value
//  start        in   1       begin reset+load sequence
//  busy         out  1       high in any reset/load state
//  loaded       out  1       high in RUN_WAIT/RUN_LO/RUN_HI
//  s_valid      in   1       sample available
//  s_data       in   BW_in   sample
//  s_ready      out  1       sample accepted this cycle when s_valid&s_ready
//  m_valid      out  1       result valid
//  m_data       out  BW_out  result (low BW_out bits of FIR sum)
//  m_ready      in   1       result consumed when m_valid&m_ready
//  fir_io_in    out  8       to tile: {0.., data, fir_rst, fir_clk}
//  fir_io_out   in   8       from tile; registered once on entry (io_q)
// BEHAVIOUR
//  Reset: state IDLE, fir_io_in=0, busy/loaded/s_ready/m_valid=0, m_data=0, primed=0, coefficient regs=0.
//  cfg writes: accepted in IDLE and RUN_WAIT only; cfg_addr>=N_TAPS ignored. Writes take effect at the next start.
//  FSM: IDLE -> RST_LO -> RST_HI -> LD_LO -> LD_HI (repeated N_TAPS times) -> RUN_WAIT <-> RUN_LO -> RUN_HI.
//  Every LO and HI state lasts exactly HALF_PERIOD cycles. fir_clk=1 only in *_HI states.
//  start: honoured in IDLE or RUN_WAIT, ignored elsewhere. It clears m_valid and primed and enters RST_LO next cycle.
//  RST_LO/RST_HI: fir_rst=1, data=0. fir_rst is 0 in all other states. The tile therefore sees exactly one rising edge with reset high.
//  LD k (k=0..N_TAPS-1): data=coef[N_TAPS-1-k], latched at LD_LO entry and held through LD_HI.
//  After the last LD_HI, the FSM enters RUN_WAIT.
//  RUN_WAIT: s_ready = s_valid-independent (!m_valid | m_ready). There is no combinational path from s_valid to s_ready.
//  A handshake in cycle t latches s_data.
//   t+1..t+H: RUN_LO with data=sample.
//   t+H+1..t+2H: RUN_HI.
//   At cycle t+2H, if primed, m_data<=io_q[BW_out-1:0] and m_valid<=1. primed<=1 regardless.
//   FSM is back in RUN_WAIT at t+2H+1. Throughput: one sample per 2H+1 cycles minimum.
//  Result timing: the tile's sum lags one edge, so the result reflecting sample n is emitted on the step of sample n+1.
//   The first step after load emits nothing. The last sample's result needs one more sample (feed 0 to flush).
//  m_valid&m_ready clears m_valid unless a capture sets it in the same cycle (capture wins).
//  Because s_ready requires a free slot, a capture never overwrites an unconsumed result.
//  Data and fir_rst are stable across each full LO+HI step. They only change on entry to a LO state.
//  Reset mid-operation: immediate return to IDLE. fir_io_in=0 next cycle, and any partial FIR edge is abandoned.
//  Arithmetic: none internal. m_data is the tile's truncated sum and wraps modulo 2^BW_out.
// TESTING
//  1. Impulse (H=4): coef[0..5]=1,2,3,4,5,6; start; feed 1,0,0,0,0,0,0,0 -> m_data 1,2,3,4,5,6,0.
//  2. Load order: after start, fir_io_in[1]=1 for exactly 8 cycles with one fir_clk rise.
//     Then 6 rises with data coef[5]..coef[0], and busy=0 after the last.
//  3. Sign/wrap: coef[0]=6'h3F (-1), others 0; feed 5,0 -> m_data=8'hFB.
//     coef[0]=31, feed 31,0 -> m_data=8'hC1.
//  4. Backpressure: hold m_ready=0 with m_valid=1 -> s_ready=0, fir_clk static, m_data unchanged.
//     Release -> s_ready=1 in the same cycle.
//  5. Reset mid-load (during LD_HI of tap 3) -> next cycle fir_io_in=0, busy=0, loaded=0, m_valid=0.
//  6. Restart: start in RUN_WAIT with a pending result -> m_valid drops, full reset+load repeats.
//     The first post-load sample emits nothing.

Source files
------------

// File: rtl/fir_io_driver.sv
// Host-side driver for the 6-tap FIR tile: resets the tile, serially loads the
// coefficients, then streams samples one FIR clock step each and returns results.
module fir_io_driver #(
    parameter int N_TAPS      = 6,
    parameter int BW_in       = 6,
    parameter int BW_out      = 8,
    parameter int HALF_PERIOD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [BW_in-1:0]  cfg_data,
    input  logic              start,
    output logic              busy,
    output logic              loaded,
    input  logic              s_valid,
    input  logic [BW_in-1:0]  s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [BW_out-1:0] m_data,
    input  logic              m_ready,
    output logic [7:0]        fir_io_in,
    input  logic [7:0]        fir_io_out,
    output logic [2:0]        dbg_state_o
);

    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam int TW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_LO   = 3'd1;
    localparam logic [2:0] ST_RST_HI   = 3'd2;
    localparam logic [2:0] ST_LD_LO    = 3'd3;
    localparam logic [2:0] ST_LD_HI    = 3'd4;
    localparam logic [2:0] ST_RUN_WAIT = 3'd5;
    localparam logic [2:0] ST_RUN_LO   = 3'd6;
    localparam logic [2:0] ST_RUN_HI   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tap_q, tap_d;
    logic [BW_in-1:0]  data_q, data_d;
    logic [BW_in-1:0]  coef_q [N_TAPS];
    logic [BW_in-1:0]  coef_d [N_TAPS];
    logic [7:0]        io_q;
    logic              m_valid_q, m_valid_d;
    logic [BW_out-1:0] m_data_q, m_data_d;
    logic              primed_q, primed_d;

    logic              idle_like;
    logic              timed;
    logic              phase_end;
    logic              cfg_ok;
    logic [TW-1:0]     ld_next_idx;
    logic [BW_in-1:0]  coef_sel;

    assign idle_like   = (state_q == ST_IDLE) || (state_q == ST_RUN_WAIT);
    assign timed       = !idle_like;
    assign phase_end   = (cnt_q == CW'(HALF_PERIOD - 1));
    assign cfg_ok      = cfg_we && idle_like;
    assign ld_next_idx = (state_q == ST_RST_HI) ? TW'(N_TAPS - 1) : (tap_q - TW'(1));

    // Coefficients go out highest index first so the tile's shift chain ends
    // with coef[k] multiplying the sample delayed by k.
    always_comb begin
        coef_sel = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (ld_next_idx == TW'(i)) coef_sel = coef_q[i];
        end
    end

    // Stream handshake: a beat transfers on any cycle where valid and ready are
    // both high; ready never depends on valid, and valid holds until accepted.
    assign s_ready = (state_q == ST_RUN_WAIT) && (!m_valid_q || m_ready);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        tap_d     = tap_q;
        data_d    = data_q;
        coef_d    = coef_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        primed_d  = primed_q;

        if (timed && !phase_end) cnt_d = cnt_q + CW'(1);

        for (int i = 0; i < N_TAPS; i++) begin
            if (cfg_ok && (cfg_addr == 3'(i))) coef_d[i] = cfg_data;
        end

        if (m_valid_q && m_ready) m_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN_WAIT: begin
                if (start) begin
                    state_d   = ST_RST_LO;
                    data_d    = '0;
                    m_valid_d = 1'b0;
                    primed_d  = 1'b0;
                end else if ((state_q == ST_RUN_WAIT) && s_valid && s_ready) begin
                    state_d = ST_RUN_LO;
                    data_d  = s_data;
                end
            end
            ST_RST_LO: if (phase_end) state_d = ST_RST_HI;
            ST_RST_HI: begin
                if (phase_end) begin
                    state_d = ST_LD_LO;
                    tap_d   = ld_next_idx;
                    data_d  = coef_sel;
                end
            end
            ST_LD_LO: if (phase_end) state_d = ST_LD_HI;
            ST_LD_HI: begin
                if (phase_end) begin
                    if (tap_q == '0) begin
                        state_d = ST_RUN_WAIT;
                    end else begin
                        state_d = ST_LD_LO;
                        tap_d   = ld_next_idx;
                        data_d  = coef_sel;
                    end
                end
            end
            ST_RUN_LO: if (phase_end) state_d = ST_RUN_HI;
            ST_RUN_HI: begin
                if (phase_end) begin
                    state_d  = ST_RUN_WAIT;
                    primed_d = 1'b1;
                    // The tile's sum lags one edge, so the first step after load has nothing to report.
                    if (primed_q) begin
                        m_valid_d = 1'b1;
                        m_data_d  = io_q[BW_out-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tap_q     <= '0;
            data_q    <= '0;
            coef_q    <= '{default: '0};
            io_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            primed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tap_q     <= tap_d;
            data_q    <= data_d;
            coef_q    <= coef_d;
            io_q      <= fir_io_out;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            primed_q  <= primed_d;
        end
    end

    always_comb begin
        fir_io_in             = '0;
        fir_io_in[0]          = (state_q == ST_RST_HI) || (state_q == ST_LD_HI) || (state_q == ST_RUN_HI);
        fir_io_in[1]          = (state_q == ST_RST_LO) || (state_q == ST_RST_HI);
        fir_io_in[BW_in+1:2]  = data_q;
    end

    assign busy        = (state_q == ST_RST_LO) || (state_q == ST_RST_HI) ||
                         (state_q == ST_LD_LO)  || (state_q == ST_LD_HI);
    assign loaded      = (state_q == ST_RUN_WAIT) || (state_q == ST_RUN_LO) || (state_q == ST_RUN_HI);
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_io_driver.sv
// Bench for fir_io_driver: a behavioural FIR tile hangs off fir_io_in/out, and
// expected results come from a direct convolution over the samples fed since start.
`timescale 1ns/1ps
module tb_fir_io_driver;

    localparam int N = 6;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [5:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       busy, loaded;
    logic       s_valid = 1'b0;
    logic [5:0] s_data = '0;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b1;
    logic [7:0] fir_io_in;
    logic [7:0] fir_io_out;
    logic [2:0] dbg_state;

    int checks = 0;
    int failures = 0;

    logic [7:0]        exp_q[$];
    logic [7:0]        got_q[$];
    int                hist[$];
    logic signed [5:0] ref_cfg [N] = '{default: '0};
    logic signed [5:0] act_coef [N] = '{default: '0};

    fir_io_driver #(.N_TAPS(N), .BW_in(6), .BW_out(8), .HALF_PERIOD(H)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .busy(busy), .loaded(loaded), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fir_io_in(fir_io_in), .fir_io_out(fir_io_out), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // behavioural FIR tile: reset on a rising edge with rst high, then N loads, then samples
    logic       tile_clk;
    int         t_coef [N] = '{default: 0};
    int         t_x [N] = '{default: 0};
    int         t_ld = 0;
    logic [7:0] t_out = 8'h00;
    assign tile_clk   = fir_io_in[0];
    assign fir_io_out = t_out;

    always @(posedge tile_clk) begin : tile
        int d;
        int acc;
        d = int'($signed(fir_io_in[7:2]));
        if (fir_io_in[1]) begin
            t_ld  = 0;
            t_out = 8'h00;
            for (int i = 0; i < N; i++) t_x[i] = 0;
        end else if (t_ld < N) begin
            for (int i = N - 1; i > 0; i--) t_coef[i] = t_coef[i-1];
            t_coef[0] = d;
            t_ld++;
        end else begin
            acc = 0;
            for (int i = 0; i < N; i++) acc += t_coef[i] * t_x[i];
            t_out = 8'(acc);
            for (int i = N - 1; i > 0; i--) t_x[i] = t_x[i-1];
            t_x[0] = d;
        end
    end

    // result monitor: one entry per m_valid/m_ready transfer
    always @(negedge clk) begin
        if (reset === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
    end

    function automatic logic [7:0] ref_y(int m);
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            if (m - k >= 0) acc += int'(act_coef[k]) * hist[m-k];
        end
        return 8'(acc);
    endfunction

    // driver tasks (all start and end 1ns after a rising edge)
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [5:0] d, input bit honoured);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick(1);
        cfg_we = 1'b0;
        if (honoured && int'(a) < N) ref_cfg[a] = d;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        act_coef = ref_cfg;
        hist.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic wait_loaded();
        int n;
        n = 0;
        while (loaded !== 1'b1 && n < 200) begin tick(1); n++; end
        checks++;
        if (loaded !== 1'b1) begin
            failures++;
            $display("FAIL load_timeout loaded=%b after %0d cycles, required 1", loaded, n);
        end
    endtask

    task automatic send_sample(input logic [5:0] v);
        int n;
        s_valid = 1'b1; s_data = v;
        #1;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin tick(1); n++; end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL s_ready_timeout s_ready=%b after %0d cycles, required 1", s_ready, n);
            s_valid = 1'b0;
            return;
        end
        tick(1);
        s_valid = 1'b0;
        hist.push_back(int'($signed(v)));
        if (hist.size() >= 2) exp_q.push_back(ref_y(hist.size() - 2));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks += 6;
        if (fir_io_in !== 8'h00) begin failures++; $display("FAIL rst_io got=%h exp=00", fir_io_in); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (loaded !== 1'b0)     begin failures++; $display("FAIL rst_loaded got=%b exp=0", loaded); end
        if (s_ready !== 1'b0)    begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        if (m_valid !== 1'b0)    begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        if (m_data !== 8'h00)    begin failures++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_impulse();
        logic [7:0] tab [7];
        logic [7:0] g;
        tab = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0};
        for (int i = 0; i < N; i++) write_coef(3'(i), 6'(i + 1), 1'b1);
        do_start();
        wait_loaded();
        m_ready = 1'b1;
        send_sample(6'd1);
        for (int i = 0; i < 7; i++) send_sample(6'd0);
        tick(2 * H + 4);
        checks++;
        if (got_q.size() != 7) begin failures++; $display("FAIL impulse_count got=%0d exp=7", got_q.size()); end
        for (int i = 0; i < 7 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            checks++;
            if (g !== tab[i]) begin failures++; $display("FAIL impulse_y%0d got=%h exp=%h", i, g, tab[i]); end
        end
    endtask

    task automatic test_load_order();
        int n, rst_cyc, rst_rise, ld_rise;
        bit prev;
        logic [5:0] ld_val [N];
        logic [7:0] e, g;
        for (int i = 0; i < N; i++) write_coef(3'(i), 6'($urandom_range(0, 63)), 1'b1);
        do_start();
        n = 0; rst_cyc = 0; rst_rise = 0; ld_rise = 0; prev = 1'b0;
        while (loaded !== 1'b1 && n < 200) begin
            if (fir_io_in[1]) rst_cyc++;
            if (fir_io_in[0] && !prev) begin
                if (fir_io_in[1]) rst_rise++;
                else begin
                    if (ld_rise < N) ld_val[ld_rise] = fir_io_in[7:2];
                    ld_rise++;
                end
            end
            prev = fir_io_in[0];
            // a write while busy must be dropped
            cfg_we = (n == 20); cfg_addr = 3'd0; cfg_data = ~ref_cfg[0];
            tick(1);
            n++;
        end
        cfg_we = 1'b0;
        checks += 5;
        if (n != 2 * H * (N + 1)) begin failures++; $display("FAIL load_cycles got=%0d exp=%0d", n, 2 * H * (N + 1)); end
        if (rst_cyc != 2 * H)     begin failures++; $display("FAIL rst_high_cycles got=%0d exp=%0d", rst_cyc, 2 * H); end
        if (rst_rise != 1)        begin failures++; $display("FAIL rst_rises got=%0d exp=1", rst_rise); end
        if (ld_rise != N)         begin failures++; $display("FAIL ld_rises got=%0d exp=%0d", ld_rise, N); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL busy_after_load got=%b exp=0", busy); end
        for (int k = 0; k < N && k < ld_rise; k++) begin
            checks++;
            if (ld_val[k] !== ref_cfg[N-1-k]) begin
                failures++; $display("FAIL ld_data%0d got=%h exp=%h", k, ld_val[k], ref_cfg[N-1-k]);
            end
        end
        for (int i = 0; i < 6; i++) send_sample(6'($urandom_range(0, 63)));
        send_sample(6'd0);
        tick(2 * H + 4);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL load_res_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL load_res got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_sign_wrap();
        logic [7:0] g;
        write_coef(3'd0, 6'h3F, 1'b1);
        for (int i = 1; i < N; i++) write_coef(3'(i), 6'd0, 1'b1);
        do_start(); wait_loaded();
        send_sample(6'd5); send_sample(6'd0);
        tick(2 * H + 4);
        checks += 2;
        if (got_q.size() != 1) begin failures++; $display("FAIL neg_count got=%0d exp=1", got_q.size()); end
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        if (g !== 8'hFB) begin failures++; $display("FAIL neg_one_x5 got=%h exp=fb", g); end
        write_coef(3'd0, 6'd31, 1'b1);
        do_start(); wait_loaded();
        send_sample(6'd31); send_sample(6'd0);
        tick(2 * H + 4);
        checks += 2;
        if (got_q.size() != 1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", got_q.size()); end
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        if (g !== 8'hC1) begin failures++; $display("FAIL wrap_31x31 got=%h exp=c1", g); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e, g;
        logic       clk_lvl;
        do_start(); wait_loaded();
        m_ready = 1'b0;
        send_sample(6'($urandom_range(1, 63)));
        send_sample(6'($urandom_range(0, 63)));
        tick(2 * H + 2);
        e = exp_q[0];
        clk_lvl = fir_io_in[0];
        s_valid = 1'b1; s_data = 6'($urandom_range(0, 63));
        for (int i = 0; i < 20; i++) begin
            checks += 4;
            if (m_valid !== 1'b1)         begin failures++; $display("FAIL bp_m_valid c%0d got=%b exp=1", i, m_valid); end
            if (s_ready !== 1'b0)         begin failures++; $display("FAIL bp_s_ready c%0d got=%b exp=0", i, s_ready); end
            if (fir_io_in[0] !== clk_lvl) begin failures++; $display("FAIL bp_fir_clk c%0d got=%b exp=%b", i, fir_io_in[0], clk_lvl); end
            if (m_data !== e)             begin failures++; $display("FAIL bp_m_data c%0d got=%h exp=%h", i, m_data, e); end
            tick(1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_release_s_ready got=%b exp=1", s_ready); end
        tick(1);
        checks++;
        if (got_q.size() != 1) begin failures++; $display("FAIL bp_count got=%0d exp=1", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL bp_result got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e, g;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) write_coef(3'(i), 6'($urandom), 1'b1);
            write_coef(3'($urandom_range(6, 7)), 6'($urandom), 1'b1);
            do_start(); wait_loaded();
            for (int s = 0; s < 16; s++) begin
                m_ready = 1'b0;
                tick($urandom_range(0, 3));
                m_ready = 1'b1;
                send_sample(6'($urandom));
            end
            send_sample(6'd0);
            tick(2 * H + 4);
            checks++;
            if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count r%0d got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                checks++;
                if (g !== e) begin failures++; $display("FAIL rand_result r%0d got=%h exp=%h", r, g, e); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int n, rises;
        bit prev;
        do_start();
        n = 0; rises = 0; prev = 1'b0;
        while (rises < 5 && n < 200) begin
            if (fir_io_in[0] && !prev) rises++;
            prev = fir_io_in[0];
            if (rises < 5) begin tick(1); n++; end
        end
        tick(1);
        checks += 2;
        if (rises != 5)    begin failures++; $display("FAIL midload_reach rises=%0d exp=5", rises); end
        if (busy !== 1'b1) begin failures++; $display("FAIL midload_busy got=%b exp=1", busy); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks += 4;
        if (fir_io_in !== 8'h00) begin failures++; $display("FAIL midload_io got=%h exp=00", fir_io_in); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL midload_busy_after got=%b exp=0", busy); end
        if (loaded !== 1'b0)     begin failures++; $display("FAIL midload_loaded got=%b exp=0", loaded); end
        if (m_valid !== 1'b0)    begin failures++; $display("FAIL midload_m_valid got=%b exp=0", m_valid); end
        tick(2);
        // register reset cleared the coefficient file
        for (int i = 0; i < N; i++) ref_cfg[i] = '0;
    endtask

    task automatic test_restart();
        logic [7:0] e, g;
        for (int i = 0; i < N; i++) write_coef(3'(i), 6'($urandom), 1'b1);
        do_start(); wait_loaded();
        m_ready = 1'b0;
        send_sample(6'($urandom)); send_sample(6'($urandom));
        tick(2 * H + 2);
        checks++;
        if (m_valid !== 1'b1) begin failures++; $display("FAIL restart_pending got=%b exp=1", m_valid); end
        do_start();
        checks += 2;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL restart_m_valid got=%b exp=0", m_valid); end
        if (busy !== 1'b1)    begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
        wait_loaded();
        m_ready = 1'b1;
        send_sample(6'($urandom));
        tick(2 * H + 4);
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL restart_first_silent got=%0d exp=0", got_q.size()); end
        for (int i = 0; i < 4; i++) send_sample(6'($urandom));
        send_sample(6'd0);
        tick(2 * H + 4);
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL restart_result got=%h exp=%h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_load_order();
        test_sign_wrap();
        test_backpressure();
        test_random();
        test_reset_mid_load();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
